send_data: RTL and testbench

Parallel-to-serial configuration sender that sits directly upstream of the shift-register (SR) chain and its readback receiver. On a start request it captures a WIDTH-bit configuration word, shifts it out LSB first on `din_sr` with a per-bit shift enable, then pulses `load_sr` so the chain latches the word and the downstream receiver begins capturing readback. A one-cycle `done` pulse closes the transaction.

---
 rtl/send_data_pkg.sv | 16 +
 rtl/send_data_piso_shreg.sv | 33 +++
 rtl/send_data.sv | 100 ++++++++++
 tb/tb_send_data.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/send_data_pkg.sv
// Shared definitions for the configuration sender and its readback receiver.
package send_data_pkg;

  // Configuration word length shared with the downstream receiver.
  localparam int CFG_WIDTH = 170;
  localparam int CFG_CNT_W = 8;

  // One-hot sender states.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SHIFT = 4'b0010,
    S_LOAD  = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

endpackage

// File: rtl/send_data_piso_shreg.sv
// WIDTH-bit parallel-load, right-shift register with zero fill; q0 is the serial output.
module piso_shreg #(
  parameter int WIDTH = 170
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q0
);

  logic [WIDTH-1:0] q;

  // Clear has priority over load, load over shift.
  // NOTE: the data register is reset too, so din_sr is a defined 0 out of reset
  // and no stale configuration bits can leak into the SR chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {1'b0, q[WIDTH-1:1]};
    end
  end

  assign q0 = q[0];

endmodule

// File: rtl/send_data.sv
// Parallel-to-serial configuration sender feeding the SR chain.
// Serial data leaves LSB first straight from the shift register's bit 0, so
// din_sr is a flop output; control outputs are registered from the next state.
module send_data
  import send_data_pkg::*;
#(
  parameter int WIDTH = CFG_WIDTH,
  parameter int CNT_W = CFG_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             din_sr,
  output logic             sr_en,
  output logic             load_sr,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             state_legal;

  assign accept      = (state == S_IDLE) && start;
  assign state_legal = (state == S_IDLE) || (state == S_SHIFT) ||
                       (state == S_LOAD) || (state == S_DONE);

  // Data path: capture on accept, shift every SHIFT cycle (the final shift
  // empties the register so din_sr reads 0 during LOAD), flush on an upset.
  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr   (!state_legal),
    .load  (accept),
    .shift (state == S_SHIFT),
    .d     (din),
    .q0    (din_sr)
  );

  // Sequencer: state, bit counter and registered control outputs.
  // NOTE: non-blocking assignments throughout, so every branch sees the
  // pre-edge values of state and cnt regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sr_en   <= 1'b0;
      load_sr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sr_en   <= 1'b0;
      load_sr <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state <= S_SHIFT;
            cnt   <= '0;
            sr_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          busy <= 1'b1;
          if (cnt == LAST_BIT) begin
            // Hold cnt at its last value so it never passes WIDTH-1.
            state   <= S_LOAD;
            load_sr <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            sr_en <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_DONE;
          busy  <= 1'b1;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_send_data.sv
// Directed bench for send_data: a 170-bit instance with an SR-chain/receiver
// loopback model and an 8-bit instance for boundary and back-to-back cases.
module tb_send_data;

  localparam int W = 170;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         start170 = 1'b0;
  logic [W-1:0] din170   = '0;
  logic         din_sr170, sr_en170, load_sr170, busy170, done170;

  logic       start8 = 1'b0;
  logic [7:0] din8   = '0;
  logic       din_sr8, sr_en8, load_sr8, busy8, done8;

  int tests = 0;
  int fails = 0;

  // Downstream SR chain and readback receiver, both sampling on negedge.
  logic [W-1:0] chain = '0;
  logic [W-1:0] rx    = '0;

  always #5 clk = ~clk;

  send_data #(.WIDTH(W), .CNT_W(8)) dut170 (
    .clk(clk), .rst(rst), .start(start170), .din(din170),
    .din_sr(din_sr170), .sr_en(sr_en170), .load_sr(load_sr170),
    .busy(busy170), .done(done170)
  );

  send_data #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .din(din8),
    .din_sr(din_sr8), .sr_en(sr_en8), .load_sr(load_sr8),
    .busy(busy8), .done(done8)
  );

  always @(negedge clk) begin
    if (sr_en170) chain <= {din_sr170, chain[W-1:1]};
    if (load_sr170) rx <= chain;
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full 170-bit send with per-bit stream check and receiver loopback check.
  task automatic send170(input logic [W-1:0] v, input string tag);
    din170   = v;
    start170 = 1'b1;
    step();
    start170 = 1'b0;
    for (int k = 0; k < W; k++) begin
      check({tag, "_bit"}, {sr_en170, busy170, din_sr170}, {2'b11, v[k]});
      step();
    end
    check({tag, "_load"}, {sr_en170, load_sr170, busy170, done170, din_sr170}, 5'b01100);
    step();
    check({tag, "_done"}, {sr_en170, load_sr170, busy170, done170, din_sr170}, 5'b00110);
    step();
    check({tag, "_idle"}, {sr_en170, load_sr170, busy170, done170, din_sr170}, 5'b00000);
    check({tag, "_loopback"}, rx, v);
  endtask

  // Full 8-bit send with stream, counter ceiling and tail checks.
  task automatic send8(input logic [7:0] v, input string tag);
    din8   = v;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check({tag, "_bit"}, {sr_en8, busy8, din_sr8}, {2'b11, v[k]});
      step();
    end
    check({tag, "_load"}, {sr_en8, load_sr8, busy8, done8, din_sr8}, 5'b01100);
    check({tag, "_cnt"}, dut8.cnt, 8'd7);
    step();
    check({tag, "_done"}, {sr_en8, load_sr8, busy8, done8, din_sr8}, 5'b00110);
    check({tag, "_cnt_hold"}, dut8.cnt, 8'd7);
    step();
    check({tag, "_idle"}, {sr_en8, load_sr8, busy8, done8, din_sr8}, 5'b00000);
  endtask

  initial begin
    logic [W-1:0] alt;
    logic [W-1:0] rnd;
    int n_acc, n_sr, n_ld;
    logic prev_busy;

    // Reset state of both instances.
    #1 rst = 1'b1;
    #1;
    check("reset170", {din_sr170, sr_en170, load_sr170, busy170, done170}, 5'b00000);
    check("reset8", {din_sr8, sr_en8, load_sr8, busy8, done8}, 5'b00000);
    step();
    step();
    rst = 1'b0;
    step();
    check("idle170", {din_sr170, sr_en170, load_sr170, busy170, done170}, 5'b00000);

    // Basic send of alternating bits 0,1,0,1,... (170'h2AAA...A).
    for (int i = 0; i < W; i++) alt[i] = i[0];
    send170(alt, "alt");

    // Width boundary: 8'h81 streams 1,0,0,0,0,0,0,1.
    send8(8'h81, "w8_81");
    send8(8'h3C, "w8_3c");

    // din changes to all-ones before edge 3 of a send of 8'h00.
    din8   = 8'h00;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("din_hold_bit", {sr_en8, din_sr8}, 2'b10);
      if (k == 2) din8 = 8'hFF;
      step();
    end
    check("din_hold_load", {sr_en8, load_sr8, din_sr8}, 3'b010);
    step();
    step();
    check("din_hold_idle", busy8, 1'b0);
    din8 = 8'h00;

    // start held high: accepts at edges 0, 11, 22, 33 within edges 0..39.
    start8    = 1'b1;
    prev_busy = busy8;
    n_acc = 0;
    n_sr  = 0;
    n_ld  = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (busy8 && !prev_busy) begin
        check("accept_edge", e, 11 * n_acc);
        n_acc++;
      end
      prev_busy = busy8;
      if (sr_en8) n_sr++;
      if (load_sr8) n_ld++;
      check("no_overlap", {sr_en8 & load_sr8, sr_en8 & done8, load_sr8 & done8}, 3'b000);
    end
    start8 = 1'b0;
    check("accept_count", n_acc, 4);
    check("sr_en_count", n_sr, 31);
    check("load_count", n_ld, 3);
    for (int e = 0; e < 5; e++) step();
    check("held_idle", {sr_en8, load_sr8, busy8, done8}, 4'b0000);

    // Reset asserted mid-shift at bit 50.
    for (int i = 0; i < 6; i++) rnd[i*32 +: 32] = $urandom;
    din170   = rnd;
    start170 = 1'b1;
    step();
    start170 = 1'b0;
    for (int k = 0; k < 50; k++) step();
    check("mid_bit50", {sr_en170, din_sr170}, {1'b1, rnd[50]});
    rst = 1'b1;
    #1;
    check("async_reset", {din_sr170, sr_en170, load_sr170, busy170, done170}, 5'b00000);
    step();
    rst = 1'b0;
    n_ld = 0;
    for (int e = 0; e < 200; e++) begin
      step();
      if (load_sr170) n_ld++;
    end
    check("no_load_after_reset", n_ld, 0);
    check("post_reset_idle", busy170, 1'b0);

    // Full send after reset, then a second random word through the loopback.
    send170(rnd, "post_reset");
    for (int i = 0; i < 6; i++) rnd[i*32 +: 32] = $urandom;
    send170(rnd, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
